// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// Combinational read ports and registered write ports, with an optional
// same-cycle write-to-read bypass. Register 0 always reads as zero.
// A sequential clear engine zeroes registers 1..NREG-1 after reset or on
// request. While it runs, writes are stalled and all reads return zero.
//
// Write handshake: a write on port p happens at the rising edge where
// wr_valid[p] && wr_ready. wr_ready is shared by all ports and is low only
// while the clear engine runs. A stalled requester holds wr_valid, wr_addr
// and wr_data until it sees wr_ready high.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic [NRD*$clog2(NREG)-1:0]      rd_addr,
    output logic [NRD*XLEN-1:0]              rd_data,
    input  logic [NWR-1:0]                   wr_valid,
    input  logic [NWR*$clog2(NREG)-1:0]      wr_addr,
    input  logic [NWR*XLEN-1:0]              wr_data,
    output logic                             wr_ready,
    output logic                             dbg_state_o,
    output logic [$clog2(NREG)-1:0]          dbg_cidx_o
);

    localparam int AW = $clog2(NREG);

    // S_CLEAR walks cidx over 1..NREG-1; S_IDLE serves reads and writes.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cidx_q, cidx_d;

    // Storage has no reset, so it can map to plain RAM or flops.
    logic [XLEN-1:0]   mem_q [NREG];

    // Per-port views of the packed address and data buses.
    logic [AW-1:0]     rd_a [NRD];
    logic [AW-1:0]     wr_a [NWR];
    logic [XLEN-1:0]   wr_d [NWR];
    logic [NWR-1:0]    wr_en;

    for (genvar i = 0; i < NRD; i++) begin : g_rd_unpack
        assign rd_a[i] = rd_addr[i*AW +: AW];
    end

    // A write takes effect only in IDLE and never to register 0. Writes to
    // register 0 still complete the handshake; their data is discarded.
    for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
        assign wr_a[p]  = wr_addr[p*AW +: AW];
        assign wr_d[p]  = wr_data[p*XLEN +: XLEN];
        assign wr_en[p] = wr_valid[p] && wr_ready && (wr_a[p] != '0);
    end

    assign busy        = (state_q == S_CLEAR);
    assign wr_ready    = (state_q == S_IDLE);
    assign dbg_state_o = state_q;
    assign dbg_cidx_o  = cidx_q;

    // FSM state and clear index; reset always restarts a full clear from 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cidx_q  <= AW'(1);
        end else begin
            state_q <= state_d;
            cidx_q  <= cidx_d;
        end
    end

    // Next state: advance the clear one register per cycle; start a new
    // clear from IDLE on request. clr_req is ignored while clearing.
    always_comb begin
        state_d = state_q;
        cidx_d  = cidx_q;
        case (state_q)
            S_CLEAR: begin
                if (cidx_q == AW'(NREG - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cidx_d = cidx_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cidx_d  = AW'(1);
                end
            end
            default: begin
                state_d = S_CLEAR;
                cidx_d  = AW'(1);
            end
        endcase
    end

    // Array update: clear writes while busy, otherwise the write ports in
    // ascending order so that the highest-numbered port wins a conflict.
    // A write accepted with clr_req commits here, and the clear then
    // overwrites it.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[cidx_q] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p]) begin
                    mem_q[wr_a[p]] <= wr_d[p];
                end
            end
        end
    end

    // Read ports.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] val;

        // Stored value, or the winning same-cycle write under bypass.
        // Forced to zero while clearing or for register 0.
        always_comb begin
            val = '0;
            if ((state_q == S_IDLE) && (rd_a[i] != '0)) begin
                val = mem_q[rd_a[i]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en[p] && (wr_a[p] == rd_a[i])) begin
                            val = wr_d[p];
                        end
                    end
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = val;
    end

    // Invariants of the handshake and of the clear engine.
    a_busy_not_ready : assert property (@(posedge clk) disable iff (reset)
        busy != wr_ready);
    a_clear_reads_zero : assert property (@(posedge clk) disable iff (reset)
        busy |-> (rd_data == '0));
    a_cidx_nonzero : assert property (@(posedge clk) disable iff (reset)
        (state_q == S_CLEAR) |-> (cidx_q != '0));

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next-generation RV32I cores, replacing the fixed 32×32, 2-read/1-write register file in the single-cycle datapath. It adds the following:
- configurable width, depth, read-port count and write-port count;
- optional same-cycle write-to-read bypass;
- a sequential clear engine that zeroes the array after reset or on request, with a valid/ready write handshake.

It sits between the instruction decoder (read addresses), the writeback mux (write data) and the ALU/branch/store operand paths.

## Interface
- XLEN, 32, register width in bits.
- NREG, 32, number of registers (power of two, ≥4); AW = $clog2(NREG).
- NRD, 2, number of combinational read ports (1–4).
- NWR, 1, number of write ports (1–2).
- BYPASS, 1, 1 = a read of an address being written this cycle returns the incoming data; 0 = returns the stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- clr_req  in  1  single-cycle request to zero the whole array.
- busy  out  1  clear engine active.
- rd_addr  in  NRD*AW  read addresses; port i is at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i is at [i*XLEN +: XLEN].
- wr_valid  in  NWR  per-port write request.
- wr_addr  in  NWR*AW  per-port write address.
- wr_data  in  NWR*XLEN  per-port write data.
- wr_ready  out  1  common ready for all write ports.

## Operation
- Register 0 is hardwired to zero.
  - Reads of address 0 always return 0, including under bypass.
  - Writes to address 0 are accepted (the handshake completes) and discarded.
- The FSM has two states, CLEAR and IDLE. A clear index `cidx` (AW bits) drives the clear.
- **Reset:** the FSM enters CLEAR with cidx = 1.
- **CLEAR state:**
  - Each cycle writes 0 to reg[cidx] and increments cidx.
  - When cidx = NREG-1 is written, the FSM goes to IDLE on the next edge. There is no wrap-around.
  - busy = 1 and wr_ready = 0, so write requests are stalled and not lost. The requester holds wr_valid/addr/data.
  - All rd_data ports are forced to 0.
  - clr_req is ignored.
- **IDLE state:**
  - busy = 0 and wr_ready = 1.
  - Write port p commits wr_data[p] to reg[wr_addr[p]] at the edge when wr_valid[p] & wr_ready.
  - clr_req = 1 moves the FSM to CLEAR with cidx = 1 at the next edge.
- **Write conflict (NWR = 2, same nonzero address, both valid):** port 1 wins. Bypass uses the same priority.
- **Reads:** combinational from the array.
  - With BYPASS = 1, for each read port, if any valid write in the current cycle targets rd_addr (nonzero) while wr_ready = 1, rd_data returns the winning wr_data.
  - With BYPASS = 0, rd_data returns the stored value; new data is visible the cycle after the commit.
- **clr_req and wr_valid in the same IDLE cycle:** the write commits, then the clear begins and overwrites it. The final value is 0.
- **Reset during CLEAR or IDLE:** the FSM returns immediately to CLEAR with cidx = 1 and the full clear restarts. Array contents are not reset asynchronously; only the FSM and cidx are.
- The array has no asynchronous reset, so it maps to distributed RAM/flops without a reset network.

## Timing
Reset values:
- busy = 1, wr_ready = 0, rd_data = 0.
- FSM = CLEAR, cidx = 1.

Latencies:
- A full clear takes NREG-1 cycles after reset deassertion. busy falls on the edge that ends the last clear write. For NREG = 32, busy = 0 from the 31st rising edge after reset release.
- clr_req sampled in IDLE: busy = 1 from the next edge, for NREG-1 cycles.
- Write-to-read latency is 0 cycles with BYPASS = 1 and 1 cycle with BYPASS = 0.
- Read-address-to-data is purely combinational.

## Test plan
- **Reset/clear:** assert reset for 2 cycles, then release.
  - busy is high for exactly 31 cycles and rd_data = 0 throughout.
  - Afterwards, reads of all addresses 1–31 return 0x0000_0000.
- **Write/read:** in IDLE, write 0x8765_4321 to x2 and 0xF000_0000 to x3.
  - With BYPASS = 1, rd_data port 0 (addr 2) = 0x8765_4321 in the same cycle.
  - With BYPASS = 0, it shows 0x8765_4321 one cycle later.
  - Port 1 (addr 3) = 0xF000_0000 after the commit.
- **x0 protection:** write 0xDEAD_BEEF to x0 with wr_ready = 1.
  - Handshake completes; a read of addr 0 returns 0 in the same cycle and the next cycle.
- **Dual-write conflict (NWR = 2):** port 0 writes 0x1111_1111 and port 1 writes 0x2222_2222, both to x5 in the same cycle.
  - Bypass read = 0x2222_2222; stored value = 0x2222_2222.
- **Stall during clear:** pulse clr_req with x7 = 0x55; one cycle later raise wr_valid to x7 with 0xAA and hold it.
  - wr_ready stays 0 for 31 cycles; the write then commits on the first IDLE edge.
  - x7 = 0xAA, and all other registers = 0.
- **Reset mid-clear and simultaneous clr/write:**
  - Assert reset while cidx = 10: clear restarts at 1, and busy lasts 31 cycles from release.
  - Send clr_req together with a write of 0x33 to x4 in IDLE: x4 reads 0 after the clear.
